// File: rtl/hbm_rd_issue_if.sv
// AXI3 read-address channel plus R-channel monitor taps for the HBM read issuer.
// The R taps are observed only, for returning burst credits.
interface hbm_rd_issue_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int ID_WIDTH   = 6
);
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [ID_WIDTH-1:0]   ARID;
  logic [3:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  RVALID;
  logic                  RREADY;
  logic                  RLAST;

  modport master (
    output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST,
    input  ARREADY, RVALID, RREADY, RLAST
  );

  modport slave (
    input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST,
    output ARREADY, RVALID, RREADY, RLAST
  );
endinterface

// File: rtl/hbm_rd_issue.sv
// Issues INCR read bursts for region B, then region A, with an outstanding-burst
// credit limit, then waits for all RLASTs before pulsing done.
module hbm_rd_issue #(
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 33,
  parameter int A_TAG      = 0,
  parameter int B_TAG      = 1,
  parameter int MAX_OUT    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [31:0]           len_a,
  input  logic [31:0]           len_b,
  hbm_rd_issue_if.master        m_axi,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           ar_counter,
  output logic [7:0]            outstanding
);

  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int ALIGN_BITS = 9;

  typedef enum logic [2:0] {IDLE, ISSUE_B, ISSUE_A, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_a_q;
  logic [31:0]           rem_q, beats_a_q;
  logic [4:0]            burst_beats;
  logic                  issuing, arvalid, ar_hs, r_ret;

  assign issuing     = (state_q == ISSUE_B) || (state_q == ISSUE_A);
  assign burst_beats = (rem_q > 32'd16) ? 5'd16 : rem_q[4:0];

  // ARVALID is decoded purely from registers; none of its inputs can move
  // until the handshake (outstanding can only fall meanwhile), so it is stable.
  assign arvalid = issuing && (rem_q != 32'd0) && (outstanding < 8'(MAX_OUT));
  assign ar_hs   = arvalid && m_axi.ARREADY;
  assign r_ret   = m_axi.RVALID && m_axi.RREADY && m_axi.RLAST && (outstanding != 8'd0);

  assign m_axi.ARVALID = arvalid;
  assign m_axi.ARADDR  = arvalid ? addr_q : '0;
  assign m_axi.ARID    = !arvalid ? '0 :
                         (state_q == ISSUE_B) ? ID_WIDTH'(B_TAG) : ID_WIDTH'(A_TAG);
  assign m_axi.ARLEN   = arvalid ? 4'(burst_beats - 5'd1) : '0;
  assign m_axi.ARSIZE  = 3'b101;
  assign m_axi.ARBURST = 2'b01;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ISSUE_B;
      ISSUE_B: if (rem_q == 32'd0) state_d = ISSUE_A;
      ISSUE_A: if (rem_q == 32'd0) state_d = DRAIN;
      DRAIN:   if (outstanding == 8'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      addr_a_q    <= '0;
      rem_q       <= '0;
      beats_a_q   <= '0;
      ar_counter  <= '0;
      outstanding <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        // 512-byte alignment keeps every 16-beat burst inside a 4 KB page
        addr_q     <= {addr_b[ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
        addr_a_q   <= {addr_a[ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
        rem_q      <= len_b >> BEAT_SHIFT;
        beats_a_q  <= len_a >> BEAT_SHIFT;
        ar_counter <= '0;
      end else begin
        if (state_q == ISSUE_B && rem_q == 32'd0) begin
          addr_q <= addr_a_q;
          rem_q  <= beats_a_q;
        end else if (ar_hs) begin
          addr_q <= addr_q + (ADDR_WIDTH'(burst_beats) << BEAT_SHIFT);
          rem_q  <= rem_q - 32'(burst_beats);
        end
        if (ar_hs) ar_counter <= ar_counter + 32'd1;
      end
      case ({ar_hs, r_ret})
        2'b10:   outstanding <= outstanding + 8'd1;
        2'b01:   outstanding <= outstanding - 8'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: doc/hbm_rd_issue.md
HBM_RD_ISSUE -- requirements
Module: hbm_rd_issue

Interface
REQ-001 Parameter DATA_WIDTH, default 256: AXI3 read data width; one beat is 32 bytes.
REQ-002 Parameter ID_WIDTH, default 6: ARID width.
REQ-003 Parameter ADDR_WIDTH, default 33: ARADDR width.
REQ-004 Parameter A_TAG, default 0: ARID value for A-region requests.
REQ-005 Parameter B_TAG, default 1: ARID value for B-region requests.
REQ-006 Parameter MAX_OUT, default 32: maximum number of outstanding bursts, in the range 1..255.
REQ-007 clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  single-cycle pulse that launches a job.
REQ-009 addr_a / addr_b  in  ADDR_WIDTH  base byte addresses of the A and B regions.
REQ-010 len_a / len_b  in  32  region lengths in bytes.
REQ-011 m_axi_ARVALID  out  1; m_axi_ARREADY  in  1.
REQ-012 m_axi_ARADDR  out  ADDR_WIDTH; m_axi_ARID  out  ID_WIDTH; m_axi_ARLEN  out  4.
REQ-013 m_axi_ARSIZE  out  3; m_axi_ARBURST  out  2.
REQ-014 m_axi_RVALID, m_axi_RREADY, m_axi_RLAST  in  1 each: R-channel monitor taps, used for credit return only.
REQ-015 busy  out  1; done  out  1 (one-cycle pulse); ar_counter  out  32 (accepted bursts); outstanding  out  8.

Function
REQ-016 ARSIZE SHALL be the constant 3'b101 and ARBURST the constant 2'b01 (INCR).
REQ-017 Beat counts: beats_x = len_x>>5 for each region; any residual below 32 bytes SHALL be ignored.
REQ-018 Base addresses: bits [8:0] of addr_a/addr_b SHALL be forced to 0, so bursts never cross a 4 KB boundary.
REQ-019 start SHALL be sampled only in IDLE; when sampled, the block latches addresses and beat counts. start while busy SHALL be ignored.
REQ-020 FSM states: IDLE, ISSUE_B, ISSUE_A, DRAIN, DONE.
REQ-021 Transitions:
- IDLE -> ISSUE_B on start.
- ISSUE_B -> ISSUE_A when B beats remaining = 0.
- ISSUE_A -> DRAIN when A beats remaining = 0.
- DRAIN -> DONE when outstanding = 0.
- DONE -> IDLE unconditionally.
REQ-022 A region with zero beats SHALL spend exactly one cycle in its ISSUE state and issue nothing.
REQ-023 Each burst SHALL request min(16, remaining) beats, with ARLEN = beats-1.
REQ-024 After each accepted burst, address advances by beats*32 and remaining decrements by beats.
REQ-025 ARID SHALL be B_TAG in ISSUE_B and A_TAG in ISSUE_A.
REQ-026 ARVALID SHALL assert only when remaining > 0 and outstanding < MAX_OUT.
REQ-027 Once ARVALID is asserted, it and ARADDR/ARID/ARLEN SHALL stay stable until ARVALID&ARREADY; deassertion before the handshake is forbidden.
REQ-028 ARVALID SHALL NOT depend combinationally on ARREADY.
REQ-029 After a handshake, ARVALID may re-assert in the next cycle, giving one burst per cycle at full rate.
REQ-030 Outstanding count update:
- +1 on ARVALID&ARREADY.
- -1 on RVALID&RREADY&RLAST.
- Both events in the same cycle: unchanged.
- An RLAST with outstanding = 0 SHALL NOT decrement (saturate at 0).
REQ-031 ar_counter SHALL clear on an accepted start and increment on each AR handshake.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 done SHALL be 1 exactly during the DONE cycle.

Reset
REQ-034 On rst_n=0 at a clock edge, the following SHALL take effect next cycle, including mid-burst with ARVALID high:
- State = IDLE.
- ARVALID=0, busy=0, done=0.
- outstanding=0, ar_counter=0.
- ARADDR/ARID/ARLEN = 0.
REQ-035 After reset release, the first start SHALL be accepted in the first IDLE cycle.

Verification
REQ-036 len_b=64, len_a=1024, ARREADY=1, one RLAST returned per burst: bursts are B (ARLEN=1, addr_b), then A (ARLEN=15, addr_a), then A (ARLEN=15, addr_a+512); then done; ar_counter=3.
REQ-037 len_a=33*32 (33 beats), len_b=0: A bursts have ARLEN 15, 15, 0 at offsets 0, 512, 1024.
REQ-038 MAX_OUT=2, no RLAST returned: exactly 2 handshakes, then ARVALID stays 0 and outstanding=2; two RLAST beats then let the remaining bursts proceed.
REQ-039 ARREADY held low for 5 cycles: ARVALID, ARADDR, ARID and ARLEN are constant for all 5 cycles; the handshake completes on the 6th cycle.
REQ-040 RLAST coincides with an AR handshake: outstanding is unchanged. RLAST with outstanding=0: outstanding stays 0.
REQ-041 rst_n asserted mid-job: next cycle IDLE, ARVALID=0, outstanding=0; a later start runs the full sequence.
